// File: rtl/shift_reg_universal.sv
// Universal shift register: hold, shift-up, shift-down, parallel load.
// A shared shift counter flags each completed WIDTH-bit word.
module shift_reg_universal #(
  parameter  int               WIDTH     = 4,
  parameter  logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int               CNT_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sin_lo,
  input  logic             sin_hi,
  input  logic [WIDTH-1:0] pdata_in,
  output logic [WIDTH-1:0] pdata_out,
  output logic             sout_hi,
  output logic             sout_lo,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             word_valid
);

  typedef enum logic [1:0] {
    M_HOLD = 2'b00,
    M_UP   = 2'b01,
    M_DN   = 2'b10,
    M_LOAD = 2'b11
  } mode_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  mode_e            mode_s;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wv_q, wv_d;
  logic             shift;

  assign mode_s = mode_e'(mode);

  always_comb begin
    q_d   = q_q;
    cnt_d = cnt_q;
    wv_d  = 1'b0;
    shift = 1'b0;
    if (en) begin
      unique case (mode_s)
        M_HOLD: ;
        M_UP: begin
          q_d   = {q_q[WIDTH-2:0], sin_lo};
          shift = 1'b1;
        end
        M_DN: begin
          q_d   = {sin_hi, q_q[WIDTH-1:1]};
          shift = 1'b1;
        end
        M_LOAD: begin
          q_d   = pdata_in;
          cnt_d = '0;
        end
      endcase
    end
    // both directions share one counter; wrap marks a full word
    if (shift) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
        wv_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q   <= RESET_VAL;
      cnt_q <= '0;
      wv_q  <= 1'b0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
      wv_q  <= wv_d;
    end
  end

  assign pdata_out  = q_q;
  assign sout_hi    = q_q[WIDTH-1];
  assign sout_lo    = q_q[0];
  assign bit_cnt    = cnt_q;
  assign word_valid = wv_q;

endmodule
